// File: rtl/bcd_scan_timer_if.sv
// Board-side signal bundle for bcd_scan_timer: button/control inputs and display/count outputs.
// The master side is the board (or bench); the slave side is the timer.
interface bcd_scan_timer_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    pause_button;
  logic                    clear;
  logic                    up_down;
  logic                    led;
  logic [6:0]              segmentos;
  logic [NUM_DIGITS-1:0]   displays;
  logic [4*NUM_DIGITS-1:0] count_bcd;

  modport master (
    output pause_button, clear, up_down,
    input  led, segmentos, displays, count_bcd
  );

  modport slave (
    input  pause_button, clear, up_down,
    output led, segmentos, displays, count_bcd
  );
endinterface

// File: rtl/bcd_scan_timer.sv
// Multi-digit BCD seconds counter with debounced pause toggle and a scanned
// common-anode 7-segment driver (active-low segments and digit enables).

// One BCD digit of the cascade: steps when step is high, reports carry/borrow out.
module bcd_digit_cell (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       step,
  input  logic       up,
  output logic [3:0] digit_q,
  output logic       carry
);
  logic [3:0] digit_d;

  assign carry = step & (up ? (digit_q == 4'd9) : (digit_q == 4'd0));

  always_comb begin
    digit_d = digit_q;
    if (clear)        digit_d = 4'd0;
    else if (step) begin
      if (up) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      else    digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) digit_q <= 4'd0;
    else          digit_q <= digit_d;
  end
endmodule

module bcd_scan_timer #(
  parameter int TICK_DIV        = 50000000,
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLANK_LEADING   = 0
) (
  input  logic           clock,
  input  logic           reset_n,
  bcd_scan_timer_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic                  sync1_q, sync2_q;
  logic [DW-1:0]         db_cnt_q, db_cnt_d;
  logic                  db_lvl_q, db_lvl_d;
  logic                  db_prev_q;
  logic                  paused_q, paused_d;
  logic [TW-1:0]         pre_q, pre_d;
  logic                  tick;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] disp_q, disp_d;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;

  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS:0]        step;

  assign tick    = ~paused_q & (pre_q == TICK_MAX);
  assign step[0] = tick;

  // Ripple carry/borrow chain: digit g steps only when every lower digit wraps.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_cell u_dig (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (bus.clear),
      .step    (step[g]),
      .up      (bus.up_down),
      .digit_q (digits[g]),
      .carry   (step[g+1])
    );
  end

  logic unused_top_carry;
  assign unused_top_carry = step[NUM_DIGITS];

  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (digits[i] == 4'd0);
      blank[i] = (BLANK_LEADING != 0) & zero_run;
    end
  end

  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == DB_MAX) db_lvl_d = sync2_q;
      else                    db_cnt_d = db_cnt_q + 1'b1;
    end

    // Toggle one edge after the debounced level rises; release does nothing.
    paused_d = paused_q ^ (db_lvl_q & ~db_prev_q);

    pre_d = pre_q;
    if (bus.clear)      pre_d = '0;
    else if (!paused_q) pre_d = (pre_q == TICK_MAX) ? '0 : pre_q + 1'b1;

    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
    end

    disp_d = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_d  = blank[scan_idx_q] ? 7'b1111111 : seg_decode(digits[scan_idx_q]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_cnt_q   <= '0;
      db_lvl_q   <= 1'b0;
      db_prev_q  <= 1'b0;
      paused_q   <= 1'b0;
      pre_q      <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= 7'b1111111;
      disp_q     <= '1;
    end else begin
      sync1_q    <= bus.pause_button;
      sync2_q    <= sync1_q;
      db_cnt_q   <= db_cnt_d;
      db_lvl_q   <= db_lvl_d;
      db_prev_q  <= db_lvl_q;
      paused_q   <= paused_d;
      pre_q      <= pre_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      disp_q     <= disp_d;
    end
  end

  assign bus.led       = paused_q;
  assign bus.segmentos = seg_q;
  assign bus.displays  = disp_q;
  assign bus.count_bcd = digits;
endmodule

// File: tb/tb_bcd_scan_timer.sv
// Directed bench for bcd_scan_timer: two instances (leading-zero blanking on/off)
// share stimulus; expected values are hand-computed cycle counts and patterns.
module tb_bcd_scan_timer;
  localparam int ND = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc;
  int   n_chk   = 0;
  int   n_pass  = 0;

  always #5 clock = ~clock;

  // Posedges since reset release; drives the expected scan phase.
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  bcd_scan_timer_if #(.NUM_DIGITS(ND)) bus_a ();
  bcd_scan_timer_if #(.NUM_DIGITS(ND)) bus_b ();

  assign bus_b.pause_button = bus_a.pause_button;
  assign bus_b.clear        = bus_a.clear;
  assign bus_b.up_down      = bus_a.up_down;

  bcd_scan_timer #(.TICK_DIV(4), .NUM_DIGITS(ND), .SCAN_DIV(2),
                   .DEBOUNCE_CYCLES(3), .BLANK_LEADING(1)) dut_a (
    .clock (clock), .reset_n (reset_n), .bus (bus_a));

  bcd_scan_timer #(.TICK_DIV(4), .NUM_DIGITS(ND), .SCAN_DIV(2),
                   .DEBOUNCE_CYCLES(3), .BLANK_LEADING(0)) dut_b (
    .clock (clock), .reset_n (reset_n), .bus (bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_disp;
    bus_a.pause_button = 1'b0;
    bus_a.clear        = 1'b0;
    bus_a.up_down      = 1'b1;
    cycles(3);
    chk("rst_disp",  bus_a.displays,  2'b11);
    chk("rst_seg",   bus_a.segmentos, 7'b1111111);
    chk("rst_seg_b", bus_b.segmentos, 7'b1111111);
    chk("rst_cnt",   bus_a.count_bcd, 8'h00);
    chk("rst_led",   bus_a.led,       1'b0);
    reset_n = 1'b1;

    // Up count: one step per 4 cycles, wrap at 99.
    cycles(40);  chk("up_10",   bus_a.count_bcd, 8'h10);
    cycles(356); chk("up_99",   bus_a.count_bcd, 8'h99);
    cycles(4);   chk("up_wrap", bus_a.count_bcd, 8'h00);

    bus_a.up_down = 1'b0;
    cycles(4); chk("dn_wrap", bus_a.count_bcd, 8'h99);
    cycles(4); chk("dn_98",   bus_a.count_bcd, 8'h98);

    // Short glitch is rejected.
    bus_a.pause_button = 1'b1; cycles(2);
    bus_a.pause_button = 1'b0; cycles(6);
    chk("glitch_led", bus_a.led,       1'b0);
    chk("glitch_cnt", bus_a.count_bcd, 8'h96);

    // Held press pauses after sync + debounce + toggle edge.
    bus_a.pause_button = 1'b1; cycles(10);
    chk("pause_led", bus_a.led,       1'b1);
    chk("pause_cnt", bus_a.count_bcd, 8'h95);
    bus_a.pause_button = 1'b0; cycles(10);
    chk("rel_led", bus_a.led,       1'b1);
    chk("frz_cnt", bus_a.count_bcd, 8'h95);

    // Resume: prescaler was frozen at 2, so the tick lands 2 cycles after resume.
    bus_a.pause_button = 1'b1; cycles(6);
    chk("resume_led", bus_a.led,       1'b0);
    chk("resume_cnt", bus_a.count_bcd, 8'h95);
    cycles(1); chk("resume_p3",  bus_a.count_bcd, 8'h95);
    cycles(1); chk("resume_tik", bus_a.count_bcd, 8'h94);

    bus_a.pause_button = 1'b0; cycles(8);
    chk("run_cnt", bus_a.count_bcd, 8'h92);
    chk("run_led", bus_a.led,       1'b0);

    // Clear held, then clear colliding with a tick at 57.
    bus_a.clear = 1'b1; bus_a.up_down = 1'b1;
    cycles(1); chk("clr_cnt",  bus_a.count_bcd, 8'h00);
    cycles(4); chk("clr_hold", bus_a.count_bcd, 8'h00);
    bus_a.clear = 1'b0;
    cycles(231); chk("cnt_57", bus_a.count_bcd, 8'h57);
    bus_a.clear = 1'b1;
    cycles(1);
    chk("clr_tick_cnt", bus_a.count_bcd, 8'h00);
    chk("clr_tick_led", bus_a.led,       1'b0);
    bus_a.clear = 1'b0;
    cycles(3); chk("clr_pre0", bus_a.count_bcd, 8'h00);
    cycles(1); chk("clr_pre4", bus_a.count_bcd, 8'h01);

    // Freeze at 07 and check the scanned display.
    cycles(20); chk("cnt_06", bus_a.count_bcd, 8'h06);
    bus_a.pause_button = 1'b1; cycles(10);
    chk("frz07_led", bus_a.led,       1'b1);
    chk("frz07_a",   bus_a.count_bcd, 8'h07);
    chk("frz07_b",   bus_b.count_bcd, 8'h07);
    for (int k = 0; k < 8; k++) begin
      cycles(1);
      exp_disp = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 2'b10 : 2'b01;
      chk("scan_disp", bus_a.displays, exp_disp);
      chk("scan_seg_blank", bus_a.segmentos,
          (exp_disp == 2'b10) ? 7'b0001111 : 7'b1111111);
      chk("scan_seg_noblank", bus_b.segmentos,
          (exp_disp == 2'b10) ? 7'b0001111 : 7'b0000001);
    end

    // Asynchronous reset between edges.
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_disp",  bus_a.displays,  2'b11);
    chk("arst_seg",   bus_a.segmentos, 7'b1111111);
    chk("arst_seg_b", bus_b.segmentos, 7'b1111111);
    chk("arst_cnt",   bus_a.count_bcd, 8'h00);
    chk("arst_cnt_b", bus_b.count_bcd, 8'h00);
    chk("arst_led",   bus_a.led,       1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
